led_decoder_ctrl: RTL

//  Parametrised registered select-to-LED driver, successor to the fixed 3-to-8 decoder.

---
 rtl/led_decoder_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/led_decoder_ctrl.sv
// Registered select-to-LED driver with DECODE / BLINK / CHASE / BAR display modes.
// Optional PWM brightness gating is compiled in when LED_PWM_EN is defined.
module led_decoder_ctrl #(
    parameter int         SEL_W    = 3,
    parameter logic [2:0] EN_MATCH = 3'b100,
    parameter int         DIV_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               enable,
    input  logic [SEL_W-1:0]         switch,
    input  logic [1:0]               mode,
    input  logic [3:0]               duty,
    output logic [(1 << SEL_W)-1:0]  led
);
    localparam int N_LED = 1 << SEL_W;

    typedef enum logic [1:0] {
        MODE_DECODE = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BAR    = 2'd3
    } mode_t;

    localparam logic [N_LED-1:0] ONE_N  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED:0]   TWO_N1 = {{(N_LED-1){1'b0}}, 2'b10};

    logic [DIV_W-1:0] r_presc;
    logic             r_phase;
    logic [SEL_W-1:0] r_pos;
    logic [1:0]       r_mode_q;
    logic [N_LED-1:0] r_led;

    mode_t            w_mode;
    logic             w_en;
    logic             w_tick;
    logic             w_chase_entry;
    logic             w_phase_next;
    logic [SEL_W-1:0] w_pos_next;
    logic [N_LED:0]   w_bar_wide;
    logic [N_LED-1:0] w_pattern;
    logic [N_LED-1:0] w_led_next;

    assign w_mode        = mode_t'(mode);
    assign w_en          = (enable == EN_MATCH);
    assign w_tick        = &r_presc;
    assign w_chase_entry = (w_mode == MODE_CHASE) && (r_mode_q != MODE_CHASE);
    // Extra top bit lets switch = N_LED-1 produce an all-ones bar mask.
    assign w_bar_wide    = (TWO_N1 << switch) - {{N_LED{1'b0}}, 1'b1};

    always_comb begin
        w_phase_next = r_phase;
        if (w_en && (w_mode == MODE_BLINK) && w_tick)
            w_phase_next = ~r_phase;
    end

    // Chase entry loads the start position even while the display is disabled.
    always_comb begin
        w_pos_next = r_pos;
        if (w_chase_entry)
            w_pos_next = switch;
        else if ((w_mode == MODE_CHASE) && w_en && w_tick)
            w_pos_next = r_pos + {{(SEL_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        w_pattern = '1;
        case (w_mode)
            MODE_DECODE: w_pattern = ~(ONE_N << switch);
            MODE_BLINK:  w_pattern = w_phase_next ? ~(ONE_N << switch) : '1;
            MODE_CHASE:  w_pattern = ~(ONE_N << w_pos_next);
            MODE_BAR:    w_pattern = ~w_bar_wide[N_LED-1:0];
            default:     w_pattern = '1;
        endcase
    end

`ifdef LED_PWM_EN
    logic [3:0] r_pwm;
    logic       w_pwm_on;

    assign w_pwm_on = (r_pwm < duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 4'd1;
    end

    always_comb begin
        w_led_next = '1;
        if (w_en)
            w_led_next = w_pattern | {N_LED{~w_pwm_on}};
    end
`else
    logic w_unused_duty;
    assign w_unused_duty = ^duty;

    always_comb begin
        w_led_next = '1;
        if (w_en)
            w_led_next = w_pattern;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_phase  <= 1'b0;
            r_pos    <= '0;
            r_mode_q <= MODE_DECODE;
            r_led    <= '1;
        end else begin
            r_presc  <= r_presc + {{(DIV_W-1){1'b0}}, 1'b1};
            r_phase  <= w_phase_next;
            r_pos    <= w_pos_next;
            r_mode_q <= mode;
            r_led    <= w_led_next;
        end
    end

    assign led = r_led;

endmodule
